// File: rtl/gpo.sv
// rtl/gpo.sv - CSR-mapped general-purpose outputs with optional one-shot pulses
// Pulse function (PULSE/PLEN registers, prescaler, counters) present when GPO_PULSE_EN is defined.
module gpo #(
  parameter logic [4:0]  BASE_ADDR   = 5'd0,
  parameter int          NUM_GPIOS   = 8,
  parameter logic [7:0]  RESET_VALUE = 8'h00,
  parameter logic [15:0] PRESCALE    = 16'd1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           csr_a,
  input  logic [7:0]           csr_di,
  input  logic                 csr_we,
  output logic [7:0]           csr_do,
  output logic [NUM_GPIOS-1:0] out
);

  localparam logic [4:0] ADDR_OUT = BASE_ADDR;

  logic [NUM_GPIOS-1:0] out_reg;
  logic [NUM_GPIOS-1:0] out_reg_next;
  logic [NUM_GPIOS-1:0] busy;
  logic [NUM_GPIOS-1:0] busy_next;
  logic                 wr_out;

  assign wr_out = csr_we && (csr_a == ADDR_OUT);

  always_comb begin
    out_reg_next = out_reg;
    if (wr_out) out_reg_next = csr_di[NUM_GPIOS-1:0];
  end

`ifdef GPO_PULSE_EN
  localparam logic [4:0] ADDR_PULSE = BASE_ADDR + 5'd1;
  localparam logic [4:0] ADDR_PLEN  = BASE_ADDR + 5'd2;

  logic [15:0]          pre_cnt;
  logic                 tick;
  logic [7:0]           plen;
  logic [7:0]           cnt      [NUM_GPIOS];
  logic [7:0]           cnt_next [NUM_GPIOS];
  logic [NUM_GPIOS-1:0] trig;

  assign tick = (pre_cnt == PRESCALE - 16'd1);

  // A trigger load takes priority over a tick decrement in the same cycle.
  always_comb begin
    trig      = '0;
    busy      = '0;
    busy_next = '0;
    for (int n = 0; n < NUM_GPIOS; n++) begin
      trig[n] = csr_we && (csr_a == ADDR_PULSE) && csr_di[n] && (plen != 8'd0);
      busy[n] = (cnt[n] != 8'd0);
      if (trig[n])
        cnt_next[n] = plen;
      else if (tick && busy[n])
        cnt_next[n] = cnt[n] - 8'd1;
      else
        cnt_next[n] = cnt[n];
      busy_next[n] = (cnt_next[n] != 8'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      plen    <= 8'd10;
      for (int n = 0; n < NUM_GPIOS; n++) cnt[n] <= 8'd0;
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (csr_we && (csr_a == ADDR_PLEN)) plen <= csr_di;
      for (int n = 0; n < NUM_GPIOS; n++) cnt[n] <= cnt_next[n];
    end
  end

  always_comb begin
    csr_do = 8'h00;
    if (csr_a == ADDR_OUT)
      csr_do = 8'(out_reg);
    else if (csr_a == ADDR_PULSE)
      csr_do = 8'(busy);
    else if (csr_a == ADDR_PLEN)
      csr_do = plen;
  end
`else
  assign busy      = '0;
  assign busy_next = '0;

  always_comb begin
    csr_do = 8'h00;
    if (csr_a == ADDR_OUT) csr_do = 8'(out_reg);
  end
`endif

  // out is computed from next-state values so writes and pulse edges show at the sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= RESET_VALUE[NUM_GPIOS-1:0];
      out     <= RESET_VALUE[NUM_GPIOS-1:0];
    end else begin
      out_reg <= out_reg_next;
      out     <= out_reg_next ^ busy_next;
    end
  end

endmodule

// File: tb/tb_gpo.sv
// tb/tb_gpo.sv - directed self-checking bench for gpo, two instances sharing one CSR bus
module tb_gpo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'h00;
  logic       csr_we = 1'b0;
  logic [7:0] do0, do1;
  logic [7:0] out0;
  logic [3:0] out1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpo #(.BASE_ADDR(5'd0), .NUM_GPIOS(8), .RESET_VALUE(8'hA5), .PRESCALE(16'd1)) u0 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(do0), .out(out0)
  );

  gpo #(.BASE_ADDR(5'd4), .NUM_GPIOS(4), .RESET_VALUE(8'h00), .PRESCALE(16'd4)) u1 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(do1), .out(out1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(posedge clk);
    #1;
    csr_we = 1'b0;
  endtask

  task automatic rd0(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(tag, do0, exp);
  endtask

  task automatic rd1(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(tag, do1, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_out0", out0, 8'hA5);
    chk("rst_out1", {4'h0, out1}, 8'h00);
    rd0("rst_rd_out", 5'd0, 8'hA5);
    rd0("rst_rd_unmapped3", 5'd3, 8'h00);
    rd1("u1_rd_addr0", 5'd0, 8'h00);
`ifdef GPO_PULSE_EN
    rd0("rst_rd_plen", 5'd2, 8'd10);
    rd0("rst_rd_pulse", 5'd1, 8'h00);
`else
    rd0("rst_rd_addr1", 5'd1, 8'h00);
    rd0("rst_rd_addr2", 5'd2, 8'h00);
`endif

    // NUM_GPIOS=4 masking and zero-latency write
    wr(5'd4, 8'hFF);
    chk("n4_out_ff", {4'h0, out1}, 8'h0F);
    chk("n4_u0_untouched", out0, 8'hA5);
    rd1("n4_rd_out", 5'd4, 8'h0F);
    wr(5'd4, 8'h00);
    chk("n4_out_00", {4'h0, out1}, 8'h00);

`ifdef GPO_PULSE_EN
    // PRESCALE=1 high-going 3-cycle pulse
    wr(5'd0, 8'h00);
    wr(5'd2, 8'd3);
    wr(5'd1, 8'h01);
    chk("p1_start", out0, 8'h01);
    rd0("p1_busy", 5'd1, 8'h01);
    step(1); chk("p1_c1", out0, 8'h01);
    step(1); chk("p1_c2", out0, 8'h01);
    step(1); chk("p1_end", out0, 8'h00);
    rd0("p1_idle", 5'd1, 8'h00);

    // low-going pulse
    wr(5'd0, 8'h01);
    chk("p1l_level", out0, 8'h01);
    wr(5'd1, 8'h01);
    chk("p1l_start", out0, 8'h00);
    step(2); chk("p1l_c2", out0, 8'h00);
    step(1); chk("p1l_end", out0, 8'h01);

    // OUT write coinciding with pulse end: new OUT value wins
    wr(5'd2, 8'd1);
    wr(5'd1, 8'h02);
    chk("coinc_start", out0, 8'h03);
    wr(5'd0, 8'h0F);
    chk("coinc_end", out0, 8'h0F);

    // PRESCALE=4 retrigger; reset edge is edge 0, ticks on edges 4, 8, 12
    do_reset();
    wr(5'd6, 8'd2);                                  // edge 1
    wr(5'd5, 8'h04);                                 // edge 2, cnt=2
    chk("p4_start", {4'h0, out1}, 8'h04);
    rd1("p4_busy", 5'd5, 8'h04);
    step(4); chk("p4_e6", {4'h0, out1}, 8'h04);      // tick at 4 -> cnt=1
    wr(5'd5, 8'h04);                                 // edge 7 retrigger, cnt=2
    step(1); chk("p4_e8_ext", {4'h0, out1}, 8'h04);  // would have ended here
    step(3); chk("p4_e11", {4'h0, out1}, 8'h04);
    step(1); chk("p4_e12_end", {4'h0, out1}, 8'h00);
    rd1("p4_idle", 5'd5, 8'h00);

    // PLEN=0 trigger is a no-op; reset aborts pulse
    wr(5'd2, 8'd0);
    wr(5'd1, 8'hFF);
    chk("plen0_out", out0, 8'hA5);
    rd0("plen0_busy", 5'd1, 8'h00);
    wr(5'd2, 8'd5);
    wr(5'd1, 8'h02);
    chk("p5_start", out0, 8'hA7);
    step(1); chk("p5_mid", out0, 8'hA7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_out", out0, 8'hA5);
    rd0("abort_busy", 5'd1, 8'h00);
    rst = 1'b0;
`else
    wr(5'd1, 8'h01);
    chk("nopulse_out0", out0, 8'hA5);
    rd0("nopulse_rd1", 5'd1, 8'h00);
    wr(5'd2, 8'h07);
    rd0("nopulse_rd2", 5'd2, 8'h00);
    wr(5'd5, 8'h04);
    chk("nopulse_out1", {4'h0, out1}, 8'h00);
    rd1("nopulse_u1_rd5", 5'd5, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
